// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: A/D opcodes and the queued D-channel response.
package tl_ul_pkg;

  // Widest requester tag a queued response can carry; narrower tags are zero-extended.
  localparam int unsigned TL_SRC_W_MAX = 16;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_ARITH       = 3'd2,
    A_LOGICAL     = 3'd3,
    A_GET         = 3'd4,
    A_HINT        = 3'd5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1,
    D_HINT_ACK        = 3'd2
  } tl_d_op_e;

  typedef struct packed {
    tl_d_op_e                  opcode;
    logic [1:0]                size;
    logic [TL_SRC_W_MAX-1:0]   source;
    logic                      denied;
    logic [31:0]               data;
    logic                      corrupt;
  } tl_d_resp_t;

endpackage

// File: rtl/tl_resp_fifo.sv
// Circular response queue; the head entry drives the output and reads as zero when empty.
module tl_resp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = logic [7:0]
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  T                             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output T                             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;

  T                 mem_q [DEPTH];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  always_comb begin
    in_ready  = (count_q < CNT_W'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    count     = count_q;

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is not reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: rtl/tl_ul_ram_responder.sv
// TileLink-UL manager backed by a word-addressed flop RAM, answering through a response FIFO.
module tl_ul_ram_responder
  import tl_ul_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned SOURCE_W    = 5,
  parameter int unsigned RESP_DEPTH  = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [1:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [31:0]         a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  input  logic                a_corrupt,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [1:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_sink,
  output logic                d_denied,
  output logic [31:0]         d_data,
  output logic                d_corrupt
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W     = $clog2(RESP_DEPTH + 1);
  localparam logic [32:0] RANGE_END = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);

  logic [31:0]      ram_q [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic             in_range, aligned, legal, fire, wr_en;
  logic [31:0]      rd_word;
  tl_d_resp_t       resp, head;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_sigs;

  assign fire = a_valid & a_ready;

  always_comb begin
    in_range = ({1'b0, a_address} >= {1'b0, ADDR_BASE}) && ({1'b0, a_address} < RANGE_END);
    idx      = a_address[2 +: IDX_W];
    case (a_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~a_address[0];
      default: aligned = (a_address[1:0] == 2'b00);
    endcase
    legal   = in_range && aligned && (a_size != 2'd3);
    rd_word = ram_q[idx];

    resp        = '0;
    resp.opcode = D_ACCESS_ACK;
    resp.size   = a_size;
    resp.source = TL_SRC_W_MAX'(a_source);
    wr_en       = 1'b0;

    case (a_opcode)
      A_PUT_FULL, A_PUT_PARTIAL: begin
        if (legal && !a_corrupt) begin
          wr_en = fire;
        end else begin
          resp.denied = 1'b1;
        end
      end
      A_GET: begin
        resp.opcode = D_ACCESS_ACK_DATA;
        if (legal) begin
          resp.data = rd_word;
        end else begin
          resp.denied  = 1'b1;
          resp.corrupt = 1'b1;
        end
      end
      A_ARITH, A_LOGICAL: begin
        resp.opcode  = D_ACCESS_ACK_DATA;
        resp.denied  = 1'b1;
        resp.corrupt = 1'b1;
      end
      A_HINT: begin
        resp.opcode = D_HINT_ACK;
      end
      default: begin
        resp.denied = 1'b1;
      end
    endcase
  end

  // Response captures rd_word before this edge's write lands, giving read-before-write.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (a_mask[b]) begin
          ram_q[idx][8*b +: 8] <= a_data[8*b +: 8];
        end
      end
    end
  end

  tl_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .T     (tl_d_resp_t)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (a_valid),
    .in_ready  (a_ready),
    .in_data   (resp),
    .out_valid (d_valid),
    .out_ready (d_ready),
    .out_data  (head),
    .count     (fifo_count)
  );

  assign d_opcode    = head.opcode;
  assign d_param     = '0;
  assign d_size      = head.size;
  assign d_source    = head.source[SOURCE_W-1:0];
  assign d_sink      = 1'b0;
  assign d_denied    = head.denied;
  assign d_data      = head.data;
  assign d_corrupt   = head.corrupt;
  assign unused_sigs = ^{a_param, head.source, fifo_count};

endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// Directed self-checking bench for tl_ul_ram_responder with hand-computed responses.
module tb_tl_ul_ram_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param;
  logic [1:0]  a_size;
  logic [4:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_corrupt;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param, d_size;
  logic [4:0]  d_source;
  logic        d_sink, d_denied, d_corrupt;
  logic [31:0] d_data;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  always #5 clock = ~clock;

  tl_ul_ram_responder #(
    .ADDR_BASE   (32'h8000_0000),
    .DEPTH_WORDS (256),
    .SOURCE_W    (5),
    .RESP_DEPTH  (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_opcode  (a_opcode),
    .a_param   (a_param),
    .a_size    (a_size),
    .a_source  (a_source),
    .a_address (a_address),
    .a_mask    (a_mask),
    .a_data    (a_data),
    .a_corrupt (a_corrupt),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_opcode  (d_opcode),
    .d_param   (d_param),
    .d_size    (d_size),
    .d_source  (d_source),
    .d_sink    (d_sink),
    .d_denied  (d_denied),
    .d_data    (d_data),
    .d_corrupt (d_corrupt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge on which the request fired.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] sz,
                        input logic [3:0] mask, input logic [31:0] data, input logic cor,
                        input logic [4:0] src);
    int unsigned n;
    a_valid = 1'b1; a_opcode = op; a_address = addr; a_size = sz;
    a_mask = mask; a_data = data; a_corrupt = cor; a_source = src;
    n = 0;
    while (!a_ready && n < 50) begin
      @(posedge clock); #1; n++;
    end
    if (!a_ready) check("a_ready_timeout", 32'(a_ready), 32'd1);
    @(posedge clock); #1;
    a_valid = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic [2:0] op, input logic [4:0] src,
                             input logic den, input logic [31:0] data, input logic cor);
    check({tag, "_valid"},   32'(d_valid),   32'd1);
    check({tag, "_opcode"},  32'(d_opcode),  32'(op));
    check({tag, "_source"},  32'(d_source),  32'(src));
    check({tag, "_denied"},  32'(d_denied),  32'(den));
    check({tag, "_data"},    d_data,         data);
    check({tag, "_corrupt"}, 32'(d_corrupt), 32'(cor));
  endtask

  initial begin
    reset = 1'b0; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = 2'd2;
    a_source = '0; a_address = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0;
    d_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_d_data",  d_data,       32'd0);
    check("rst_d_op",    32'(d_opcode), 32'd0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;

    // PutFull then immediate Get of the same word
    do_req(3'd0, 32'h8000_0010, 2'd2, 4'hF, 32'hDEAD_BEEF, 1'b0, 5'd3);
    expect_resp("putfull", 3'd0, 5'd3, 1'b0, 32'h0, 1'b0);
    check("putfull_size", 32'(d_size), 32'd2);
    check("putfull_param_sink", 32'({d_param, d_sink}), 32'd0);
    do_req(3'd4, 32'h8000_0010, 2'd2, 4'hF, 32'h0, 1'b0, 5'd4);
    expect_resp("get1", 3'd1, 5'd4, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // PutPartial over all-ones
    do_req(3'd0, 32'h8000_0020, 2'd2, 4'hF, 32'hFFFF_FFFF, 1'b0, 5'd5);
    expect_resp("putfull2", 3'd0, 5'd5, 1'b0, 32'h0, 1'b0);
    do_req(3'd1, 32'h8000_0020, 2'd2, 4'h5, 32'h1122_3344, 1'b0, 5'd6);
    expect_resp("putpart", 3'd0, 5'd6, 1'b0, 32'h0, 1'b0);
    do_req(3'd4, 32'h8000_0020, 2'd2, 4'hF, 32'h0, 1'b0, 5'd7);
    expect_resp("get_part", 3'd1, 5'd7, 1'b0, 32'hFF22_FF44, 1'b0);

    // Range and alignment boundaries
    do_req(3'd4, 32'h7FFF_FFFC, 2'd2, 4'hF, 32'h0, 1'b0, 5'd8);
    expect_resp("get_below", 3'd1, 5'd8, 1'b1, 32'h0, 1'b1);
    do_req(3'd4, 32'h8000_0002, 2'd2, 4'hF, 32'h0, 1'b0, 5'd9);
    expect_resp("get_misal", 3'd1, 5'd9, 1'b1, 32'h0, 1'b1);
    do_req(3'd4, 32'h8000_0400, 2'd2, 4'hF, 32'h0, 1'b0, 5'd13);
    expect_resp("get_above", 3'd1, 5'd13, 1'b1, 32'h0, 1'b1);
    do_req(3'd0, 32'h8000_03FC, 2'd2, 4'hF, 32'hCAFE_0001, 1'b0, 5'd14);
    expect_resp("put_top", 3'd0, 5'd14, 1'b0, 32'h0, 1'b0);
    do_req(3'd4, 32'h8000_03FC, 2'd2, 4'hF, 32'h0, 1'b0, 5'd15);
    expect_resp("get_top", 3'd1, 5'd15, 1'b0, 32'hCAFE_0001, 1'b0);

    // Backpressure: three Gets with d_ready low, only two fit
    @(posedge clock); #1;
    d_ready = 1'b0;
    a_valid = 1'b1; a_opcode = 3'd4; a_size = 2'd2; a_mask = 4'hF; a_corrupt = 1'b0;
    a_address = 32'h8000_0010; a_source = 5'd10;
    @(posedge clock); #1;
    a_address = 32'h8000_0020; a_source = 5'd11;
    @(posedge clock); #1;
    a_address = 32'h8000_0010; a_source = 5'd12;
    check("bp_a_ready_full", 32'(a_ready), 32'd0);
    expect_resp("bp_head", 3'd1, 5'd10, 1'b0, 32'hDEAD_BEEF, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check("bp_a_ready_hold", 32'(a_ready), 32'd0);
    expect_resp("bp_head_stable", 3'd1, 5'd10, 1'b0, 32'hDEAD_BEEF, 1'b0);
    d_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_a_ready_free", 32'(a_ready), 32'd1);
    expect_resp("bp_second", 3'd1, 5'd11, 1'b0, 32'hFF22_FF44, 1'b0);
    @(posedge clock); #1;
    a_valid = 1'b0;
    expect_resp("bp_third", 3'd1, 5'd12, 1'b0, 32'hDEAD_BEEF, 1'b0);
    @(posedge clock); #1;
    check("bp_drained", 32'(d_valid), 32'd0);

    // Poisoned put, hint, arith, reserved opcode
    do_req(3'd0, 32'h8000_0010, 2'd2, 4'hF, 32'h0000_0000, 1'b1, 5'd16);
    expect_resp("put_corrupt", 3'd0, 5'd16, 1'b1, 32'h0, 1'b0);
    do_req(3'd4, 32'h8000_0010, 2'd2, 4'hF, 32'h0, 1'b0, 5'd17);
    expect_resp("get_after_corrupt", 3'd1, 5'd17, 1'b0, 32'hDEAD_BEEF, 1'b0);
    do_req(3'd5, 32'h8000_0010, 2'd2, 4'hF, 32'h0, 1'b0, 5'd18);
    expect_resp("hint", 3'd2, 5'd18, 1'b0, 32'h0, 1'b0);
    do_req(3'd2, 32'h8000_0010, 2'd2, 4'hF, 32'h1, 1'b0, 5'd19);
    expect_resp("arith", 3'd1, 5'd19, 1'b1, 32'h0, 1'b1);
    do_req(3'd6, 32'h8000_0010, 2'd2, 4'hF, 32'h1, 1'b0, 5'd20);
    expect_resp("op6", 3'd0, 5'd20, 1'b1, 32'h0, 1'b0);
    @(posedge clock); #1;

    // Reset with two responses queued
    d_ready = 1'b0;
    do_req(3'd4, 32'h8000_0010, 2'd2, 4'hF, 32'h0, 1'b0, 5'd21);
    do_req(3'd4, 32'h8000_0020, 2'd2, 4'hF, 32'h0, 1'b0, 5'd22);
    check("pre_rst_full", 32'(a_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_d_valid", 32'(d_valid), 32'd0);
    check("mid_rst_a_ready", 32'(a_ready), 32'd1);
    @(negedge clock) reset = 1'b1;
    d_ready = 1'b1;
    @(posedge clock); #1;
    do_req(3'd4, 32'h8000_0010, 2'd2, 4'hF, 32'h0, 1'b0, 5'd23);
    expect_resp("get_post_rst", 3'd1, 5'd23, 1'b0, 32'hDEAD_BEEF, 1'b0);
    @(posedge clock); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
